rf_write_sched: RTL and testbench
=================================

RF_WRITE_SCHED -- requirements
Module: rf_write_sched

Interface
REQ-001 SHALL have parameter NREGS, 15, number of writable registers r0..r14.
REQ-002 SHALL have parameter DW, 32, data width.
REQ-003 SHALL have parameter AW, 4, register address width; address 4'b1111 is the PC (r15), not writable.
REQ-004 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports REQ0_V input 1, REQ0_A input AW, REQ0_D input DW, REQ0_RDY output 1: ALU writeback requester.
REQ-007 SHALL have ports REQ1_V input 1, REQ1_A input AW, REQ1_D input DW, REQ1_RDY output 1: load writeback requester.
REQ-008 SHALL have ports CLAIM_V input 1, CLAIM_A input AW: issue stage marks a destination register pending.
REQ-009 SHALL have port BUSY  output NREGS  pending-write bit per register (scoreboard).
REQ-010 SHALL have ports WE3 output 1, A3 output AW, WD3 output DW: drive the register-file write port.
REQ-011 SHALL have port INIT_DONE  output 1  high once the clear sequence has finished.
REQ-012 SHALL have port ERR  output 1  sticky flag: a write or claim targeted address 15.

Function
REQ-013 SHALL implement FSM states INIT and RUN; INIT -> RUN after the write to r14; RUN is terminal until reset.
REQ-014 In INIT, SHALL drive WE3=1, WD3=0, A3=0,1,...,14 on consecutive cycles (15 cycles), then set INIT_DONE=1 from the first RUN cycle.
REQ-015 In INIT, REQ0_RDY and REQ1_RDY SHALL be 0 and CLAIM_V SHALL be ignored.
REQ-016 A transfer SHALL occur on port n when REQn_V && REQn_RDY at a rising edge; at most one transfer per cycle.
REQ-017 In RUN, REQn_RDY SHALL be combinational: REQ0_RDY = !REQ1_V || last_grant==1; REQ1_RDY = !REQ0_V || last_grant==0.
REQ-018 last_grant SHALL update to the port that transferred; it is unchanged in cycles without a transfer (round-robin, no starvation).
REQ-019 WE3/A3/WD3 SHALL be registered: a transfer at edge k drives the write during cycle k..k+1 (one-cycle latency); WE3=0 in cycles following no transfer.
REQ-020 A transfer with address 15 SHALL be accepted (RDY honoured) but SHALL produce WE3=0 and set ERR.
REQ-021 CLAIM_V with CLAIM_A<15 in RUN SHALL set BUSY[CLAIM_A] at the edge; CLAIM_A==15 SHALL be ignored and set ERR.
REQ-022 A transfer to register a SHALL clear BUSY[a] at the same edge it registers the write.
REQ-023 Simultaneous claim and transfer to the same register SHALL leave BUSY[a]=1 (set wins).
REQ-024 A transfer to a register whose BUSY bit is 0 SHALL still be written; BUSY stays 0.
REQ-025 ERR SHALL remain 1 until reset.

Reset
REQ-026 RST_N low SHALL immediately force: state=INIT, init counter=0, last_grant=1, WE3=0, A3=0, WD3=0, BUSY=0, INIT_DONE=0, ERR=0, REQ0_RDY=REQ1_RDY=0.
REQ-027 Reset asserted mid-INIT or mid-RUN SHALL abandon in-flight writes; after release, the full 15-cycle clear SHALL restart from r0.

Structure
REQ-028 Package rf_sched_pkg SHALL hold NREGS, DW, AW, PC_ADDR (4'b1111) and the INIT/RUN state type.
REQ-029 The two-way round-robin grant SHALL be a sub-module rr_arb2 (inputs two valids, last_grant; outputs two readies); everything else stays in rf_write_sched.

Verification
REQ-030 Reset release -> WE3=1, WD3=0, A3 0..14 on 15 consecutive cycles, then INIT_DONE=1, REQ0_V held high throughout sees RDY=0 until RUN.
REQ-031 RUN, REQ0 only, A=3, D=32'hDEAD_BEEF -> next cycle WE3=1, A3=3, WD3=32'hDEAD_BEEF; following idle cycle WE3=0.
REQ-032 Both valid for 4 cycles, REQ0 A=1 D=10, REQ1 A=2 D=20, last_grant=1 at start -> writes alternate A3=1,2,1,2.
REQ-033 CLAIM A=5 -> BUSY[5]=1; later REQ1 A=5 -> BUSY[5]=0 at write edge; same-edge CLAIM A=6 and write A=6 -> BUSY[6]=1.
REQ-034 REQ0 A=15 D=7 -> accepted, WE3 stays 0, ERR=1 and stays 1; CLAIM A=15 -> BUSY unchanged.
REQ-035 RST_N pulsed low during RUN with BUSY=15'h0021 and pending write -> all outputs to reset values at once, WE3=0, INIT sequence restarts at A3=0.

Source files
------------

// File: rtl/rf_sched_pkg.sv
// rf_sched_pkg: shared sizes, PC address and FSM state type for the RF write scheduler
//   NREGS   writable registers r0..r14
//   DW, AW  data / register-address widths
//   PC_ADDR address of r15 (PC), never written through this path
package rf_sched_pkg;
   localparam int NREGS = 15;
   localparam int DW = 32;
   localparam int AW = 4;
   localparam logic [3:0] PC_ADDR = 4'b1111;
   typedef enum logic {INIT, RUN} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin ready generation
//   v0, v1      requester valids
//   last_grant  port that transferred most recently (0 or 1)
//   rdy0, rdy1  readies; when both are valid only the port not granted last is ready
module rr_arb2 (
   input  logic v0,
   input  logic v1,
   input  logic last_grant,
   output logic rdy0,
   output logic rdy1
);
   assign rdy0 = !v1 || last_grant;
   assign rdy1 = !v0 || !last_grant;
endmodule

// File: rtl/rf_write_sched.sv
// rf_write_sched: register-file write-port scheduler with clear sequence and pending-write scoreboard
//   CLK, RST_N                       clock, async active-low reset
//   REQ0_* / REQ1_*                  ALU / load writeback requesters (valid, addr, data, ready)
//   CLAIM_V, CLAIM_A                 issue stage marks a destination pending
//   BUSY                             pending-write bit per register
//   WE3, A3, WD3                     registered register-file write port
//   INIT_DONE                        clear sequence finished
//   ERR                              sticky: a write or claim targeted the PC
module rf_write_sched
   import rf_sched_pkg::*;
#(
   parameter int NREGS = rf_sched_pkg::NREGS,
   parameter int DW    = rf_sched_pkg::DW,
   parameter int AW    = rf_sched_pkg::AW
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             REQ0_V,
   input  logic [AW-1:0]    REQ0_A,
   input  logic [DW-1:0]    REQ0_D,
   output logic             REQ0_RDY,
   input  logic             REQ1_V,
   input  logic [AW-1:0]    REQ1_A,
   input  logic [DW-1:0]    REQ1_D,
   output logic             REQ1_RDY,
   input  logic             CLAIM_V,
   input  logic [AW-1:0]    CLAIM_A,
   output logic [NREGS-1:0] BUSY,
   output logic             WE3,
   output logic [AW-1:0]    A3,
   output logic [DW-1:0]    WD3,
   output logic             INIT_DONE,
   output logic             ERR
);
   state_t state, state_nx;
   logic [AW-1:0] cnt, wa;
   logic [DW-1:0] wd;
   logic [NREGS-1:0] clr_mask, set_mask;
   logic last_grant, run, rdy0, rdy1, xfer0, xfer1, xfer, wa_pc, claim, claim_pc;

   rr_arb2 u_arb (
      .v0         (REQ0_V),
      .v1         (REQ1_V),
      .last_grant (last_grant),
      .rdy0       (rdy0),
      .rdy1       (rdy1)
   );

   // cnt walks 0..NREGS-1 writing zeros; the extra count at NREGS lets the
   // r14 write finish before RUN (and INIT_DONE) begins
   always_comb begin
      run       = state == RUN;
      state_nx  = (state == INIT && cnt == AW'(NREGS)) ? RUN : state;
      INIT_DONE = run;
      REQ0_RDY  = run && rdy0;
      REQ1_RDY  = run && rdy1;
      xfer0     = REQ0_V && REQ0_RDY;
      xfer1     = REQ1_V && REQ1_RDY;
      xfer      = xfer0 || xfer1;
      wa        = xfer1 ? REQ1_A : REQ0_A;
      wd        = xfer1 ? REQ1_D : REQ0_D;
      wa_pc     = wa == AW'(PC_ADDR);
      claim     = run && CLAIM_V;
      claim_pc  = CLAIM_A == AW'(PC_ADDR);
      clr_mask  = (xfer && !wa_pc) ? NREGS'(1) << wa : '0;
      set_mask  = (claim && !claim_pc) ? NREGS'(1) << CLAIM_A : '0;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= INIT;
         cnt        <= '0;
         last_grant <= 1'b1;
         WE3        <= 1'b0;
         A3         <= '0;
         WD3        <= '0;
         BUSY       <= '0;
         ERR        <= 1'b0;
      end else begin
         state <= state_nx;
         if (!run) begin
            cnt <= cnt + 1'b1;
            WE3 <= cnt != AW'(NREGS);
            WD3 <= '0;
            if (cnt != AW'(NREGS)) A3 <= cnt;
         end else begin
            WE3 <= xfer && !wa_pc;
            if (xfer) begin
               A3  <= wa;
               WD3 <= wd;
            end
         end
         if (xfer) last_grant <= xfer1;
         // clear first, then set, so a same-edge claim wins
         BUSY <= (BUSY & ~clr_mask) | set_mask;
         ERR  <= ERR | (xfer && wa_pc) | (claim && claim_pc);
      end
   end
endmodule

// File: tb/tb_rf_write_sched.sv
// tb_rf_write_sched: directed + randomized self-checking bench against a behavioural model
module tb_rf_write_sched;
   logic        CLK = 1'b0, RST_N = 1'b1;
   logic        REQ0_V = 1'b0, REQ1_V = 1'b0, CLAIM_V = 1'b0;
   logic [3:0]  REQ0_A = '0, REQ1_A = '0, CLAIM_A = '0;
   logic [31:0] REQ0_D = '0, REQ1_D = '0;
   logic        REQ0_RDY, REQ1_RDY, WE3, INIT_DONE, ERR;
   logic [3:0]  A3;
   logic [31:0] WD3;
   logic [14:0] BUSY;
   int checks = 0, failures = 0;
   logic [14:0] m_busy;
   logic        m_last, m_err, m_we;
   logic [3:0]  m_a;
   logic [31:0] m_d;
   logic [3:0]  alt_exp [4];

   rf_write_sched dut (
      .CLK(CLK), .RST_N(RST_N),
      .REQ0_V(REQ0_V), .REQ0_A(REQ0_A), .REQ0_D(REQ0_D), .REQ0_RDY(REQ0_RDY),
      .REQ1_V(REQ1_V), .REQ1_A(REQ1_A), .REQ1_D(REQ1_D), .REQ1_RDY(REQ1_RDY),
      .CLAIM_V(CLAIM_V), .CLAIM_A(CLAIM_A), .BUSY(BUSY),
      .WE3(WE3), .A3(A3), .WD3(WD3), .INIT_DONE(INIT_DONE), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = '0;
      m_last = 1'b1;
      m_err  = 1'b0;
      m_we   = 1'b0;
   endtask

   task automatic idle();
      REQ0_V = 1'b0;
      REQ1_V = 1'b0;
      CLAIM_V = 1'b0;
   endtask

   // called at a negedge; one request/claim cycle, then outputs checked at the next negedge
   task automatic step(input logic v0, input logic [3:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [3:0] a1, input logic [31:0] d1,
                       input logic cv, input logic [3:0] ca);
      int win;
      logic [3:0] wa;
      logic [31:0] wdv;
      REQ0_V = v0; REQ0_A = a0; REQ0_D = d0;
      REQ1_V = v1; REQ1_A = a1; REQ1_D = d1;
      CLAIM_V = cv; CLAIM_A = ca;
      #1;
      check("rdy0", REQ0_RDY, !v1 || m_last);
      check("rdy1", REQ1_RDY, !v0 || !m_last);
      win = -1;
      if (v0 && v1) win = m_last ? 0 : 1;
      else if (v0) win = 0;
      else if (v1) win = 1;
      m_we = 1'b0;
      if (win >= 0) begin
         wa = (win == 1) ? a1 : a0;
         wdv = (win == 1) ? d1 : d0;
         m_last = (win == 1);
         if (wa == 4'd15) m_err = 1'b1;
         else begin
            m_we = 1'b1;
            m_a = wa;
            m_d = wdv;
            m_busy[wa] = 1'b0;
         end
      end
      if (cv) begin
         if (ca == 4'd15) m_err = 1'b1;
         else m_busy[ca] = 1'b1;
      end
      @(negedge CLK);
      check("we3", WE3, m_we);
      if (m_we) begin
         check("a3", A3, m_a);
         check("wd3", WD3, m_d);
      end
      check("busy", BUSY, m_busy);
      check("err", ERR, m_err);
      check("init_done", INIT_DONE, 1'b1);
   endtask

   task automatic init_seq(input int n);
      REQ0_V = 1'b1;
      REQ1_V = 1'b0;
      for (int i = 0; i < n; i++) begin
         CLAIM_V = 1'b1;
         CLAIM_A = 4'($urandom_range(0, 15));
         @(negedge CLK);
         check("init_we3", WE3, 1'b1);
         check("init_a3", A3, 64'(i));
         check("init_wd3", WD3, 0);
         check("init_done_lo", INIT_DONE, 1'b0);
         check("init_rdy0", REQ0_RDY, 1'b0);
         check("init_rdy1", REQ1_RDY, 1'b0);
      end
      if (n == 15) begin
         CLAIM_V = 1'b0;
         @(negedge CLK);
         check("run_done", INIT_DONE, 1'b1);
         check("run_we3", WE3, 1'b0);
         check("run_busy", BUSY, 0);
         check("run_err", ERR, 1'b0);
         check("run_rdy0", REQ0_RDY, 1'b1);
         idle();
      end
   endtask

   task automatic do_reset(input int n);
      RST_N = 1'b0;
      REQ0_V = 1'b1;
      REQ1_V = 1'b1;
      CLAIM_V = 1'b0;
      #1;
      check("rst_we3", WE3, 1'b0);
      check("rst_a3", A3, 0);
      check("rst_wd3", WD3, 0);
      check("rst_busy", BUSY, 0);
      check("rst_done", INIT_DONE, 1'b0);
      check("rst_err", ERR, 1'b0);
      check("rst_rdy0", REQ0_RDY, 1'b0);
      check("rst_rdy1", REQ1_RDY, 1'b0);
      model_reset();
      @(negedge CLK);
      RST_N = 1'b1;
      init_seq(n);
   endtask

   initial begin
      alt_exp[0] = 4'd1; alt_exp[1] = 4'd2; alt_exp[2] = 4'd1; alt_exp[3] = 4'd2;
      #2;
      do_reset(5);
      do_reset(15);
      step(1, 4'd3, 32'hDEAD_BEEF, 0, 4'd0, 0, 0, 4'd0);
      check("r31_we3", WE3, 1'b1);
      check("r31_a3", A3, 4'd3);
      check("r31_wd3", WD3, 32'hDEAD_BEEF);
      step(0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0);
      check("r31_idle", WE3, 1'b0);
      step(0, 4'd0, 0, 1, 4'd0, 32'h1, 0, 4'd0);
      for (int i = 0; i < 4; i++) begin
         step(1, 4'd1, 32'd10, 1, 4'd2, 32'd20, 0, 4'd0);
         check("alt_a3", A3, alt_exp[i]);
         check("alt_wd3", WD3, alt_exp[i] == 4'd1 ? 32'd10 : 32'd20);
      end
      step(0, 4'd0, 0, 0, 4'd0, 0, 1, 4'd5);
      check("claim5", BUSY[5], 1'b1);
      step(0, 4'd0, 0, 1, 4'd5, 32'h55, 0, 4'd0);
      check("clr5", BUSY[5], 1'b0);
      step(1, 4'd6, 32'h66, 0, 4'd0, 0, 1, 4'd6);
      check("setwins6", BUSY[6], 1'b1);
      check("setwins6_we", WE3, 1'b1);
      step(1, 4'd15, 32'd7, 0, 4'd0, 0, 0, 4'd0);
      check("pc_we3", WE3, 1'b0);
      check("pc_err", ERR, 1'b1);
      step(0, 4'd0, 0, 0, 4'd0, 0, 1, 4'd15);
      check("pc_claim_busy", BUSY, 15'h0040);
      check("pc_err_sticky", ERR, 1'b1);
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
              $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)));
      idle();
      do_reset(15);
      step(0, 4'd0, 0, 0, 4'd0, 0, 1, 4'd0);
      step(0, 4'd0, 0, 0, 4'd0, 0, 1, 4'd5);
      check("pre_rst_busy", BUSY, 15'h0021);
      step(1, 4'd2, 32'h1234, 0, 4'd0, 0, 0, 4'd0);
      check("pre_rst_we3", WE3, 1'b1);
      #2;
      do_reset(15);
      step(0, 4'd0, 0, 0, 4'd0, 0, 1, 4'd15);
      check("claim_pc_err", ERR, 1'b1);
      check("claim_pc_busy", BUSY, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
